// File: rtl/uart_tx_cfg.sv
// Runtime-configurable UART transmitter: start bit, 1..DATA_WIDTH data bits LSB first,
// optional even/odd parity, one or two stop bits, each bit lasting PRESCALE+1 clocks.
module uart_tx_cfg #(
    parameter int DATA_WIDTH     = 8,
    parameter int PRESCALE_WIDTH = 16,
    parameter int LEN_WIDTH      = 4
) (
    input  logic                      CLK,
    input  logic                      RST,
    input  logic [DATA_WIDTH-1:0]     P_DATA,
    input  logic                      DATA_VALID,
    input  logic [LEN_WIDTH-1:0]      DATA_LEN,
    input  logic                      PAR_EN,
    input  logic                      PAR_TYP,
    input  logic                      STOP2,
    input  logic [PRESCALE_WIDTH-1:0] PRESCALE,
    output logic                      TX_OUT,
    output logic                      busy
);

    localparam logic [LEN_WIDTH-1:0] MAX_LEN = LEN_WIDTH'(DATA_WIDTH);
    localparam logic [LEN_WIDTH-1:0] ONE_LEN = LEN_WIDTH'(1);
    localparam logic [PRESCALE_WIDTH-1:0] ONE_PRE = PRESCALE_WIDTH'(1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_PARITY,
        S_STOP1,
        S_STOP2
    } state_t;

    state_t                      state_reg, state_next;
    logic [DATA_WIDTH-1:0]       shift_reg, shift_next;
    logic [LEN_WIDTH-1:0]        len_reg, len_next;
    logic                        par_en_reg, par_en_next;
    logic                        parity_reg, parity_next;
    logic                        stop2_reg, stop2_next;
    logic [PRESCALE_WIDTH-1:0]   prescale_reg, prescale_next;
    logic [PRESCALE_WIDTH-1:0]   pre_cnt_reg, pre_cnt_next;
    logic [LEN_WIDTH-1:0]        bit_cnt_reg, bit_cnt_next;
    logic                        tx_reg, tx_next;
    logic                        busy_reg, busy_next;

    logic [LEN_WIDTH-1:0]        len_eff;
    logic [DATA_WIDTH-1:0]       len_mask;
    logic                        par_bit;
    logic                        tick;
    logic [DATA_WIDTH-1:0]       shifted;

    // Out-of-range lengths fall back to the full word width.
    assign len_eff = ((DATA_LEN == '0) || (DATA_LEN > MAX_LEN)) ? MAX_LEN : DATA_LEN;

    // Parity is computed once at acceptance, over only the bits that will be sent.
    generate
        for (genvar gi = 0; gi < DATA_WIDTH; gi++) begin : g_mask
            assign len_mask[gi] = (LEN_WIDTH'(gi) < len_eff);
        end
    endgenerate

    assign par_bit = (^(P_DATA & len_mask)) ^ PAR_TYP;
    assign tick    = (pre_cnt_reg == prescale_reg);
    assign shifted = shift_reg >> 1;

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_reg    <= S_IDLE;
            shift_reg    <= '0;
            len_reg      <= '0;
            par_en_reg   <= 1'b0;
            parity_reg   <= 1'b0;
            stop2_reg    <= 1'b0;
            prescale_reg <= '0;
            pre_cnt_reg  <= '0;
            bit_cnt_reg  <= '0;
            tx_reg       <= 1'b1;
            busy_reg     <= 1'b0;
        end else begin
            state_reg    <= state_next;
            shift_reg    <= shift_next;
            len_reg      <= len_next;
            par_en_reg   <= par_en_next;
            parity_reg   <= parity_next;
            stop2_reg    <= stop2_next;
            prescale_reg <= prescale_next;
            pre_cnt_reg  <= pre_cnt_next;
            bit_cnt_reg  <= bit_cnt_next;
            tx_reg       <= tx_next;
            busy_reg     <= busy_next;
        end
    end

    always_comb begin
        state_next    = state_reg;
        shift_next    = shift_reg;
        len_next      = len_reg;
        par_en_next   = par_en_reg;
        parity_next   = parity_reg;
        stop2_next    = stop2_reg;
        prescale_next = prescale_reg;
        pre_cnt_next  = pre_cnt_reg;
        bit_cnt_next  = bit_cnt_reg;
        tx_next       = tx_reg;

        if (state_reg != S_IDLE) begin
            pre_cnt_next = tick ? '0 : pre_cnt_reg + ONE_PRE;
        end

        // tx_next always carries the level of the bit the FSM is entering,
        // so the line changes on the same edge as the state.
        case (state_reg)
            S_IDLE: begin
                tx_next      = 1'b1;
                pre_cnt_next = '0;
                if (DATA_VALID) begin
                    shift_next    = P_DATA;
                    len_next      = len_eff;
                    par_en_next   = PAR_EN;
                    parity_next   = par_bit;
                    stop2_next    = STOP2;
                    prescale_next = PRESCALE;
                    bit_cnt_next  = '0;
                    state_next    = S_START;
                    tx_next       = 1'b0;
                end
            end
            S_START: begin
                if (tick) begin
                    state_next   = S_DATA;
                    bit_cnt_next = '0;
                    tx_next      = shift_reg[0];
                end
            end
            S_DATA: begin
                if (tick) begin
                    if (bit_cnt_reg == len_reg - ONE_LEN) begin
                        if (par_en_reg) begin
                            state_next = S_PARITY;
                            tx_next    = parity_reg;
                        end else begin
                            state_next = S_STOP1;
                            tx_next    = 1'b1;
                        end
                    end else begin
                        bit_cnt_next = bit_cnt_reg + ONE_LEN;
                        shift_next   = shifted;
                        tx_next      = shifted[0];
                    end
                end
            end
            S_PARITY: begin
                if (tick) begin
                    state_next = S_STOP1;
                    tx_next    = 1'b1;
                end
            end
            S_STOP1: begin
                tx_next = 1'b1;
                if (tick) begin
                    state_next = stop2_reg ? S_STOP2 : S_IDLE;
                end
            end
            S_STOP2: begin
                tx_next = 1'b1;
                if (tick) begin
                    state_next = S_IDLE;
                end
            end
            default: begin
                state_next = S_IDLE;
                tx_next    = 1'b1;
            end
        endcase

        busy_next = (state_next != S_IDLE);
    end

    assign TX_OUT = tx_reg;
    assign busy   = busy_reg;

endmodule

// File: tb/tb_uart_tx_cfg.sv
// Directed bench for uart_tx_cfg: inputs driven and outputs sampled on the falling edge,
// expected serial sequences written out by hand as '0'/'1' strings, first bit first.
module tb_uart_tx_cfg;

    logic        clk;
    logic        rst;
    logic [7:0]  p_data;
    logic        data_valid;
    logic [3:0]  data_len;
    logic        par_en;
    logic        par_typ;
    logic        stop2;
    logic [15:0] prescale;
    logic        tx_out;
    logic        busy;

    int errors = 0;
    int checks = 0;

    uart_tx_cfg #(
        .DATA_WIDTH(8),
        .PRESCALE_WIDTH(16),
        .LEN_WIDTH(4)
    ) dut (
        .CLK(clk),
        .RST(rst),
        .P_DATA(p_data),
        .DATA_VALID(data_valid),
        .DATA_LEN(data_len),
        .PAR_EN(par_en),
        .PAR_TYP(par_typ),
        .STOP2(stop2),
        .PRESCALE(prescale),
        .TX_OUT(tx_out),
        .busy(busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic test_reset();
        @(negedge clk);
        rst = 1'b1; data_valid = 1'b1; p_data = 8'h00;
        for (int c = 0; c < 2; c++) begin
            @(negedge clk);
            checks++;
            if (tx_out !== 1'b1 || busy !== 1'b0) begin
                errors++;
                $display("FAIL reset_hold cycle %0d: tx=%b busy=%b, required tx=1 busy=0", c, tx_out, busy);
            end
        end
        rst = 1'b0; data_valid = 1'b0;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            checks++;
            if (tx_out !== 1'b1 || busy !== 1'b0) begin
                errors++;
                $display("FAIL reset_idle cycle %0d: tx=%b busy=%b, required tx=1 busy=0", c, tx_out, busy);
            end
        end
        $display("test_reset done");
    endtask

    // Frames: (label, data, len, par_en, par_typ, stop2) at PRESCALE=0
    task automatic test_frames_p0();
        string       seq  [5];
        logic [7:0]  dat  [5];
        logic [3:0]  len  [5];
        logic        pen  [5];
        logic        ptyp [5];
        string       name [5];
        seq[0] = "0100111111";  dat[0] = 8'hF9; len[0] = 4'd8; pen[0] = 0; ptyp[0] = 0; name[0] = "basic8";
        seq[1] = "01001111111"; dat[1] = 8'hF9; len[1] = 4'd8; pen[1] = 1; ptyp[1] = 1; name[1] = "odd_par";
        seq[2] = "01001111101"; dat[2] = 8'hF9; len[2] = 4'd8; pen[2] = 1; ptyp[2] = 0; name[2] = "even_par";
        seq[3] = "0100111111";  dat[3] = 8'hF9; len[3] = 4'd0; pen[3] = 0; ptyp[3] = 0; name[3] = "len0_full";
        seq[4] = "0101";        dat[4] = 8'hF9; len[4] = 4'd1; pen[4] = 1; ptyp[4] = 1; name[4] = "len1_odd";
        for (int f = 0; f < 5; f++) begin
            @(negedge clk);
            p_data = dat[f]; data_len = len[f]; par_en = pen[f]; par_typ = ptyp[f];
            stop2 = 1'b0; prescale = 16'd0; data_valid = 1'b1;
            for (int i = 0; i < seq[f].len(); i++) begin
                @(negedge clk);
                data_valid = 1'b0;
                checks++;
                if (tx_out !== (seq[f][i] == "1") || busy !== 1'b1) begin
                    errors++;
                    $display("FAIL %s bit %0d: tx=%b busy=%b, required tx=%s busy=1", name[f], i, tx_out, busy, seq[f].substr(i, i));
                end
            end
            @(negedge clk);
            checks++;
            if (tx_out !== 1'b1 || busy !== 1'b0) begin
                errors++;
                $display("FAIL %s end: tx=%b busy=%b, required tx=1 busy=0", name[f], tx_out, busy);
            end
            $display("frame %s len=%0d bits checked", name[f], seq[f].len());
        end
    endtask

    task automatic test_prescale_stop2();
        string seq = "010011111";
        @(negedge clk);
        p_data = 8'hF9; data_len = 4'd5; par_en = 1'b1; par_typ = 1'b0;
        stop2 = 1'b1; prescale = 16'd3; data_valid = 1'b1;
        for (int c = 0; c < 36; c++) begin
            @(negedge clk);
            data_valid = 1'b0;
            checks++;
            if (tx_out !== (seq[c / 4] == "1") || busy !== 1'b1) begin
                errors++;
                $display("FAIL presc3 clock %0d: tx=%b busy=%b, required tx=%s busy=1", c, tx_out, busy, seq.substr(c / 4, c / 4));
            end
        end
        @(negedge clk);
        checks++;
        if (tx_out !== 1'b1 || busy !== 1'b0) begin
            errors++;
            $display("FAIL presc3 end: tx=%b busy=%b, required tx=1 busy=0", tx_out, busy);
        end
        $display("frame presc3 stop2 36 clocks checked");
    endtask

    task automatic test_busy_ignore();
        string seq = "0100111111";
        @(negedge clk);
        p_data = 8'hF9; data_len = 4'd8; par_en = 1'b0; par_typ = 1'b0;
        stop2 = 1'b0; prescale = 16'd1; data_valid = 1'b1;
        for (int c = 0; c < 20; c++) begin
            @(negedge clk);
            checks++;
            if (tx_out !== (seq[c / 2] == "1") || busy !== 1'b1) begin
                errors++;
                $display("FAIL ignore clock %0d: tx=%b busy=%b, required tx=%s busy=1", c, tx_out, busy, seq.substr(c / 2, c / 2));
            end
            p_data = 8'h00; prescale = 16'd0;
            data_valid = (c < 15) ? c[0] : 1'b0;
        end
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            checks++;
            if (tx_out !== 1'b1 || busy !== 1'b0) begin
                errors++;
                $display("FAIL ignore idle %0d: tx=%b busy=%b, required tx=1 busy=0", c, tx_out, busy);
            end
        end
        $display("frame ignore_inputs checked");
    endtask

    task automatic test_back_to_back();
        string seq = "0100111111";
        @(negedge clk);
        p_data = 8'hF9; data_len = 4'd8; par_en = 1'b0; stop2 = 1'b0;
        prescale = 16'd0; data_valid = 1'b1;
        for (int f = 0; f < 2; f++) begin
            for (int i = 0; i < 10; i++) begin
                @(negedge clk);
                checks++;
                if (tx_out !== (seq[i] == "1") || busy !== 1'b1) begin
                    errors++;
                    $display("FAIL b2b frame %0d bit %0d: tx=%b busy=%b, required tx=%s busy=1", f, i, tx_out, busy, seq.substr(i, i));
                end
            end
            @(negedge clk);
            checks++;
            if (tx_out !== 1'b1 || busy !== 1'b0) begin
                errors++;
                $display("FAIL b2b gap %0d: tx=%b busy=%b, required tx=1 busy=0", f, tx_out, busy);
            end
            if (f == 1) data_valid = 1'b0;
            $display("frame b2b %0d checked", f);
        end
        @(negedge clk);
        checks++;
        if (tx_out !== 1'b1 || busy !== 1'b0) begin
            errors++;
            $display("FAIL b2b stop: tx=%b busy=%b, required tx=1 busy=0", tx_out, busy);
        end
    endtask

    task automatic test_reset_mid_frame();
        string seq = "0100111111";
        @(negedge clk);
        p_data = 8'hF9; data_len = 4'd8; par_en = 1'b0; stop2 = 1'b0;
        prescale = 16'd2; data_valid = 1'b1;
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            data_valid = 1'b0;
        end
        checks++;
        if (tx_out !== 1'b1 || busy !== 1'b1) begin
            errors++;
            $display("FAIL midrst pre: tx=%b busy=%b, required tx=1 busy=1", tx_out, busy);
        end
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        checks++;
        if (tx_out !== 1'b1 || busy !== 1'b0) begin
            errors++;
            $display("FAIL midrst edge: tx=%b busy=%b, required tx=1 busy=0", tx_out, busy);
        end
        @(negedge clk);
        checks++;
        if (tx_out !== 1'b1 || busy !== 1'b0) begin
            errors++;
            $display("FAIL midrst idle: tx=%b busy=%b, required tx=1 busy=0", tx_out, busy);
        end
        data_valid = 1'b1;
        for (int c = 0; c < 30; c++) begin
            @(negedge clk);
            data_valid = 1'b0;
            checks++;
            if (tx_out !== (seq[c / 3] == "1") || busy !== 1'b1) begin
                errors++;
                $display("FAIL midrst refr clock %0d: tx=%b busy=%b, required tx=%s busy=1", c, tx_out, busy, seq.substr(c / 3, c / 3));
            end
        end
        @(negedge clk);
        checks++;
        if (tx_out !== 1'b1 || busy !== 1'b0) begin
            errors++;
            $display("FAIL midrst end: tx=%b busy=%b, required tx=1 busy=0", tx_out, busy);
        end
        $display("frame reset_mid_frame checked");
    endtask

    initial begin
        rst = 1'b1; data_valid = 1'b0; p_data = 8'h00; data_len = 4'd8;
        par_en = 1'b0; par_typ = 1'b0; stop2 = 1'b0; prescale = 16'd0;
        test_reset();
        test_frames_p0();
        test_prescale_stop2();
        test_busy_ignore();
        test_back_to_back();
        test_reset_mid_frame();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/uart_tx_cfg.md
Name: uart_tx_cfg

Overview:
Parametrised, runtime-configurable UART transmitter that serialises one parallel word per frame onto TX_OUT. Sits between the system-side producer and the serial pin, as the next-generation replacement for the fixed 8-bit, one-bit-per-clock transmitter. Adds four features:
- configurable data length
- baud prescaler
- one or two stop bits
- per-frame configuration latching

Parameters:
DATA_WIDTH, 8, maximum data bits per frame; width of P_DATA
PRESCALE_WIDTH, 16, width of PRESCALE input
LEN_WIDTH, 4, width of DATA_LEN input; must satisfy 2**LEN_WIDTH > DATA_WIDTH

Ports:
CLK  input  1  system clock, all logic on rising edge
RST  input  1  synchronous reset, active-high
P_DATA  input  DATA_WIDTH  parallel data, LSB transmitted first
DATA_VALID  input  1  request to send P_DATA; accepted only when busy=0
DATA_LEN  input  LEN_WIDTH  data bits per frame (1..DATA_WIDTH)
PAR_EN  input  1  1 = insert parity bit after data
PAR_TYP  input  1  0 = even parity, 1 = odd parity
STOP2  input  1  0 = one stop bit, 1 = two stop bits
PRESCALE  input  PRESCALE_WIDTH  each serial bit lasts PRESCALE+1 clocks
TX_OUT  output  1  serial line, registered, idle high
busy  output  1  high from frame acceptance through end of last stop bit

Behaviour:
- Interface: one clock CLK; RST is synchronous, active-high. On any edge with RST=1:
  - TX_OUT=1, busy=0, state=IDLE.
  - Bit counter and prescale counter are cleared.
  - Reset overrides all other inputs.
- Reset mid-frame aborts the frame. TX_OUT returns to 1 at that edge; no partial stop bit is required.
- FSM states: IDLE -> START -> DATA -> [PARITY] -> STOP1 -> [STOP2] -> IDLE.
- Acceptance: at an edge in IDLE with DATA_VALID=1 and RST=0:
  - P_DATA, DATA_LEN, PAR_EN, PAR_TYP, STOP2 and PRESCALE are captured into internal registers.
  - State goes to START, TX_OUT=0 and busy=1, all at that same edge (zero-cycle latency to start bit).
- Inputs changing while busy=1 have no effect on the current frame. DATA_VALID while busy=1 is ignored (not queued).
- Bit timing:
  - A prescale counter counts 0..PRESCALE_latched. The state/bit advances at the edge where the counter equals PRESCALE_latched, and the counter then wraps to 0.
  - Each serial bit is held for exactly PRESCALE+1 clocks. PRESCALE=0 gives one bit per clock.
- DATA: transmits P_DATA_latched[0] .. P_DATA_latched[N-1], LSB first.
  - N = DATA_LEN_latched.
  - DATA_LEN=0 or DATA_LEN>DATA_WIDTH is treated as N=DATA_WIDTH.
- PARITY (only if PAR_EN_latched=1):
  - Even: XOR of the N transmitted bits.
  - Odd: inverted XOR.
  - Bits above N are excluded.
- STOP1 transmits 1. STOP2 (only if STOP2_latched=1) transmits 1.
- End of frame: at the edge ending the last stop bit, state goes to IDLE and busy=0, with TX_OUT staying 1.
  - DATA_VALID is first sampled at the following edge, so at least one idle clock separates frames.
- Frame length in clocks: (1 + N + PAR_EN + 1 + STOP2) * (PRESCALE+1).
- TX_OUT is driven from a flop only; no combinational path from inputs.

Test Plan:
1. RST=1 for 2 edges with DATA_VALID=1 -> TX_OUT=1, busy=0 throughout; no frame starts. Release RST, DATA_VALID=0 -> line stays idle 1.
2. P_DATA=0xF9, DATA_LEN=8, PAR_EN=0, STOP2=0, PRESCALE=0, DATA_VALID pulsed 1 clock -> TX_OUT sequence 0,1,0,0,1,1,1,1,1,1 on 10 consecutive clocks. busy high exactly 10 clocks.
3. Same data, PAR_EN=1: PAR_TYP=1 -> 0,1,0,0,1,1,1,1,1,1,1 (parity 1). PAR_TYP=0 -> 0,1,0,0,1,1,1,1,1,0,1 (parity 0). Each frame lasts 11 clocks.
4. P_DATA=0xF9, DATA_LEN=5, PAR_EN=1, PAR_TYP=0, STOP2=1, PRESCALE=3 -> bit sequence 0,1,0,0,1,1,1,1,1, each bit held 4 clocks. Even parity is 1 (three ones). busy high 36 clocks.
5. During a frame, change P_DATA to 0x00, toggle DATA_VALID and set PRESCALE=0 -> frame unchanged, no second frame. Hold DATA_VALID=1 continuously -> frames separated by exactly one idle high clock.
6. Assert RST during a DATA bit of a PRESCALE=2 frame -> TX_OUT=1 and busy=0 at that edge. The next accepted frame starts cleanly with a full-length start bit.
